// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the multi-cycle shift controller: default datapath
// sizes, shift operation encodings and controller state encoding.
// -----------------------------------------------------------------------------
package shift_pkg;

   // Default datapath width and matching shift-amount width (log2 of width).
   localparam int WIDTH_DEF = 32;
   localparam int SHW_DEF   = 5;

   // Shift operation encodings, as driven by the CPU control unit.
   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational single-position shifter. This is the only datapath element of
// the shift controller; it is applied once per clock to the accumulator.
//
// Ports:
//   i_acc  in  WIDTH  current accumulator value
//   i_op   in  2      operation (SLL / SRL / SRA / ROR)
//   o_acc  out WIDTH  accumulator after one-position shift
// -----------------------------------------------------------------------------
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] i_acc,
   input  op_e              i_op,
   output logic [WIDTH-1:0] o_acc
);

   always_comb begin
      // NOTE: assign a default before the case so every path drives o_acc;
      // a missing assignment on any path would infer a latch.
      o_acc = i_acc;
      case (i_op)
         OP_SLL:  o_acc = {i_acc[WIDTH-2:0], 1'b0};
         OP_SRL:  o_acc = {1'b0, i_acc[WIDTH-1:1]};
         OP_SRA:  o_acc = {i_acc[WIDTH-1], i_acc[WIDTH-1:1]};
         OP_ROR:  o_acc = {i_acc[0], i_acc[WIDTH-1:1]};
         default: o_acc = i_acc;
      endcase
   end

endmodule : shift_step

// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq
// Multi-cycle shift controller. Performs a shift of 0..WIDTH-1 positions by
// applying a single-position shift stage once per clock. Driven by the CPU
// control unit through a start/busy/done handshake.
//
// Ports:
//   clk     in  1      rising-edge clock
//   rst     in  1      asynchronous, active-high reset
//   start   in  1      request; sampled only when busy=0
//   op      in  2      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   din     in  WIDTH  operand
//   shamt   in  SHW    shift amount, 0..WIDTH-1
//   busy    out 1      high while a shift is in progress
//   done    out 1      one-cycle pulse when result becomes valid
//   result  out WIDTH  shifted value; held until the next accepted start
//
// WIDTH must be a power of two and SHW must equal log2(WIDTH).
// -----------------------------------------------------------------------------
module shift_seq
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SHW   = SHW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] din,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   // Registered state
   state_e           r_state;
   op_e              r_op;
   logic [WIDTH-1:0] r_acc;
   logic [SHW-1:0]   r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;

   // Next-state values
   state_e           w_state_nxt;
   op_e              w_op_nxt;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [SHW-1:0]   w_cnt_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic [WIDTH-1:0] w_result_nxt;

   // Accumulator after one more step with the latched operation
   logic [WIDTH-1:0] w_acc_step;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_acc (r_acc),
      .i_op  (r_op),
      .o_acc (w_acc_step)
   );

   // Next-state and register-update logic
   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;      // done is a single-cycle pulse
      w_result_nxt = r_result;

      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               // Accept: inputs are captured here and never re-sampled
               // until the operation completes.
               w_op_nxt    = op_e'(op);
               w_acc_nxt   = din;
               w_cnt_nxt   = shamt;
               w_busy_nxt  = 1'b1;
               w_state_nxt = RUN;
            end else if (r_state == DONE) begin
               w_state_nxt = IDLE;
            end
         end

         RUN: begin
            // start is ignored here; the count alone decides progress.
            if (r_cnt != '0) begin
               w_acc_nxt = w_acc_step;
               w_cnt_nxt = r_cnt - SHW'(1);
            end else begin
               // busy falls in the same cycle done rises.
               w_result_nxt = r_acc;
               w_done_nxt   = 1'b1;
               w_busy_nxt   = 1'b0;
               w_state_nxt  = DONE;
            end
         end

         default: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register. Reset aborts any shift in flight without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_op     <= OP_SLL;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         r_state  <= w_state_nxt;
         r_op     <= w_op_nxt;
         r_acc    <= w_acc_nxt;
         r_cnt    <= w_cnt_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_result <= w_result_nxt;
      end
   end

   // Outputs come straight from registers: no input-to-output paths.
   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule : shift_seq

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq
// Self-checking bench for shift_seq. Expected results are pushed to a
// scoreboard queue when an operation is started and popped when done pulses.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_shift_seq;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] din;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] result;

   typedef struct {
      logic [31:0] res;
      int          sh;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   shift_seq #(
      .WIDTH (32),
      .SHW   (5)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .din    (din),
      .shamt  (shamt),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference shift computed with whole-word operators.
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d,
                                         input logic [4:0] s);
      logic signed [31:0] sd;
      sd = d;
      case (o)
         2'b00:   model = d << s;
         2'b01:   model = d >> s;
         2'b10:   model = sd >>> s;
         default: model = (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
      endcase
   endfunction

   // Caller is at a falling edge; the next rising edge accepts the request.
   task automatic start_op(input logic [1:0] o, input logic [31:0] d,
                           input logic [4:0] s, input logic [31:0] e);
      exp_t item;
      op    = o;
      din   = d;
      shamt = s;
      start = 1'b1;
      item.res = e;
      item.sh  = int'(s);
      sb.push_back(item);
      @(negedge clk);
      start = 1'b0;
      // Operands may change freely once accepted.
      op    = 2'($urandom);
      din   = $urandom;
      shamt = 5'($urandom);
   endtask

   // Waits for done (bounded), then checks latency, result and busy profile.
   // With inject set, a stray start is pulsed while the shift is running.
   // Returns at the falling edge where done is high.
   task automatic wait_done(input string tag, input bit inject);
      int   lat      = 0;
      int   busy_cnt = 0;
      bit   seen     = 1'b0;
      exp_t e;
      for (int k = 0; k < 40; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         busy_cnt += int'(busy);
         if (inject && lat == 3) begin
            start = 1'b1;
            op    = OP_SLL;
            din   = 32'h0;
            shamt = 5'd1;
         end
         @(negedge clk);
         lat++;
         start = 1'b0;
      end
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb.pop_front();
         if (!seen) begin
            check({tag, "_timeout"}, 32'(done), 32'd1);
         end else begin
            check({tag, "_latency"}, 32'(lat), 32'(e.sh + 1));
            check({tag, "_result"}, result, e.res);
            check({tag, "_busy_on_done"}, 32'(busy), 32'd0);
            // busy is high from the cycle after acceptance up to done.
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.sh + 1));
         end
      end
   endtask

   // After a done pulse: done must stay low and result must hold.
   task automatic hold_check(input string tag, input logic [31:0] exp, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check({tag, "_done_lo"}, 32'(done), 32'd0);
         check({tag, "_hold"}, result, exp);
      end
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] rd;
      logic [4:0]  rs;

      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      din   = 32'h0;
      shamt = 5'd0;

      // Reset state, before any clock edge.
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'h0);
      check("rst_state", 32'(dut.r_state), 32'(IDLE));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Basic SLL.
      @(negedge clk);
      start_op(OP_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010);
      wait_done("sll4", 1'b0);

      // Maximum shift amount.
      @(negedge clk);
      start_op(OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
      wait_done("sra31", 1'b0);
      @(negedge clk);
      start_op(OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001);
      wait_done("srl31", 1'b0);

      // Zero and single-position shifts.
      @(negedge clk);
      start_op(OP_SLL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
      wait_done("sll0", 1'b0);
      @(negedge clk);
      start_op(OP_ROR, 32'h0000_0001, 5'd1, 32'h8000_0000);
      wait_done("ror1", 1'b0);

      // start during RUN is ignored; exactly one done pulse.
      @(negedge clk);
      start_op(OP_SRL, 32'hF000_0000, 5'd8, 32'h00F0_0000);
      wait_done("ignore", 1'b1);
      hold_check("ignore", 32'h00F0_0000, 4);

      // Back-to-back: second start issued in the done cycle.
      @(negedge clk);
      start_op(OP_ROR, 32'h1234_5678, 5'd4, 32'h8123_4567);
      wait_done("b2b_first", 1'b0);
      start_op(OP_SLL, 32'h0000_0001, 5'd2, 32'h0000_0004);
      wait_done("b2b_second", 1'b0);
      hold_check("b2b", 32'h0000_0004, 2);

      // Reset three cycles into a long shift: outputs clear without an edge.
      @(negedge clk);
      start_op(OP_SLL, 32'h0000_0003, 5'd20, 32'h0030_0000);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", result, 32'h0);
      check("midrst_state", 32'(dut.r_state), 32'(IDLE));
      void'(sb.pop_front());
      @(negedge clk);
      rst = 1'b0;
      // The aborted shift must never report completion.
      hold_check("post_rst", 32'h0, 24);

      // Recovery after reset.
      @(negedge clk);
      start_op(OP_SRA, 32'h0000_00F0, 5'd4, 32'h0000_000F);
      wait_done("recover", 1'b0);

      // Random operations, alternating gaps and back-to-back starts.
      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         rd = $urandom;
         rs = 5'($urandom_range(0, 31));
         if (i % 2 == 0) @(negedge clk);
         start_op(ro, rd, rs, model(ro, rd, rs));
         wait_done($sformatf("rand%0d", i), 1'b0);
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_shift_seq
